recirc_ctrl: RTL

Main state machine for the PHY recirculation path. Sequences power-up and threshold configuration, then drives the recirculator's `idle` select from the occupancy of the four lane FIFOs. While `idle_out` is 1, the recirculator routes lane data to the downstream logic; while it is 0, lane data is recirculated. Also latches the FIFO almost-full/almost-empty thresholds and reports, per lane, which lanes have faulted.

---
 rtl/phy_pkg.sv | 11 +
 rtl/recirc_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/phy_pkg.sv
// phy_pkg: shared state encodings and lane count for the PHY recirculation path
package phy_pkg;
    localparam int NUM_LANES = 4;
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;
endpackage

// File: rtl/recirc_ctrl.sv
// recirc_ctrl: recirculation main FSM driving idle select, latching FIFO thresholds, capturing lane faults
// Ports: clk/reset (sync, active-high); init config request; umbral_*_in threshold candidates;
//        fifo_empty/fifo_error per-lane flags; idle_out/active_out/error_out/state decoded from the
//        state register; error_lanes sticky fault capture; umbral_*_out latched thresholds.
module recirc_ctrl
    import phy_pkg::*;
#(
    parameter int TH_W      = 3,
    parameter int IDLE_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [TH_W-1:0]      umbral_alto_in,
    input  logic [TH_W-1:0]      umbral_bajo_in,
    input  logic [NUM_LANES-1:0] fifo_empty,
    input  logic [NUM_LANES-1:0] fifo_error,
    output logic                 idle_out,
    output logic                 active_out,
    output logic                 error_out,
    output logic [NUM_LANES-1:0] error_lanes,
    output logic [2:0]           state,
    output logic [TH_W-1:0]      umbral_alto_out,
    output logic [TH_W-1:0]      umbral_bajo_out
);
    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d, cnt_inc;
    logic [NUM_LANES-1:0] lanes_d;
    logic [TH_W-1:0]      alto_d, bajo_d;
    logic                 lane_err, all_empty;

    assign lane_err  = |fifo_error;
    assign all_empty = &fifo_empty;
    // saturate so a long empty stretch never wraps back below IDLE_HOLD
    assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        lanes_d = error_lanes;
        alto_d  = umbral_alto_out;
        bajo_d  = umbral_bajo_out;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                alto_d = umbral_alto_in;
                bajo_d = umbral_bajo_in;
                if (lane_err) begin
                    state_d = ST_ERROR;
                    lanes_d = error_lanes | fifo_error;
                end else if (!init) begin
                    if (umbral_bajo_in > umbral_alto_in) begin
                        state_d = ST_ERROR;
                        lanes_d = '1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (lane_err) begin
                    state_d = ST_ERROR;
                    lanes_d = error_lanes | fifo_error;
                end else if (init) state_d = ST_INIT;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                cnt_d = all_empty ? cnt_inc : 4'd0;
                if (lane_err) begin
                    state_d = ST_ERROR;
                    lanes_d = error_lanes | fifo_error;
                end else if (init) state_d = ST_INIT;
                else if (cnt_d == 4'(IDLE_HOLD)) state_d = ST_IDLE;
            end
            ST_ERROR: lanes_d = error_lanes | fifo_error;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RESET;
            cnt_q           <= '0;
            error_lanes     <= '0;
            umbral_alto_out <= '0;
            umbral_bajo_out <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            error_lanes     <= lanes_d;
            umbral_alto_out <= alto_d;
            umbral_bajo_out <= bajo_d;
        end
    end

    assign state      = state_q;
    assign idle_out   = state_q == ST_IDLE;
    assign active_out = state_q == ST_ACTIVE;
    assign error_out  = state_q == ST_ERROR;
endmodule
